// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, constants and lane helpers for the memory access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeNop  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned TimeoutDefault = 255;

    function automatic logic [3:0] lane_enables(input mem_size_e size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SizeByte: be = 4'b0001 << offset;
            SizeHalf: be = offset[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_wdata(input mem_size_e size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SizeByte: rep = {4{data[7:0]}};
            SizeHalf: rep = {2{data[15:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic misaligned(input mem_size_e size, input logic [1:0] offset);
        return ((size == SizeHalf) && offset[0]) || ((size == SizeWord) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Moves the addressed bytes of a bus read word down to bit 0 and extends them by access size.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SizeByte: data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
            SizeHalf: data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit bus sequencer: IDLE -> REQ -> RESP with ack timeout.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_opcode,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          state_q;
    mem_size_e       size_q;
    logic            is_load_q;
    logic            is_unsigned_q;
    logic [1:0]      offset_q;
    logic [CntW-1:0] cnt_q;

    mem_size_e   req_size;
    logic        issue;
    logic        trap;
    logic [31:0] load_data;

    assign req_size = mem_size_e'(mem_opcode[1:0]);
    assign issue    = start && (req_size != SizeNop);

    always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
        trap = misaligned(req_size, addr[1:0]);
`else
        trap = 1'b0;
`endif
    end

    // Gated by rst_n so stall reads low throughout reset even if start is held.
    assign stall = rst_n && ((state_q == StIdle && issue) || (state_q != StIdle));

    mem_load_align u_load_align (
        .word     (bus_rdata),
        .offset   (offset_q),
        .size     (size_q),
        .zero_ext (is_unsigned_q),
        .data     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            size_q        <= SizeByte;
            is_load_q     <= 1'b0;
            is_unsigned_q <= 1'b0;
            offset_q      <= 2'b00;
            cnt_q         <= '0;
            rdata         <= '0;
            rdata_valid   <= 1'b0;
            err           <= 1'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_be        <= '0;
            bus_wdata     <= '0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        size_q        <= req_size;
                        is_load_q     <= mem_opcode[2];
                        is_unsigned_q <= mem_unsigned;
                        offset_q      <= addr[1:0];
                        cnt_q         <= '0;
                        bus_addr      <= {addr[31:2], 2'b00};
                        bus_be        <= lane_enables(req_size, addr[1:0]);
                        bus_wdata     <= replicate_wdata(req_size, wdata);
                        if (trap) begin
                            state_q <= StResp;
                            err     <= 1'b1;
                        end else begin
                            state_q <= StReq;
                            bus_req <= 1'b1;
                            bus_we  <= ~mem_opcode[2];
                        end
                    end
                end
                StReq: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (bus_ack) begin
                        state_q <= StResp;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (is_load_q) begin
                            rdata       <= load_data;
                            rdata_valid <= 1'b1;
                        end
                    end else if (cnt_q == CntMax) begin
                        state_q <= StIdle;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        err     <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed scenarios plus random accesses against a byte-level model.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mem_opcode;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_opcode  (mem_opcode),
        .mem_unsigned(mem_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte arithmetic on the address, independent of lane encoding.
    function automatic logic [3:0] m_be(input int size, input logic [31:0] a);
        int unsigned off = a % 4;
        if (size == 0) return 4'(1 << off);
        if (size == 1) return 4'(3 << ((off / 2) * 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
        if (size == 0) return (w % 256) * 32'h0101_0101;
        if (size == 1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int size, input bit uns, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] v = word >> (8 * (a % 4));
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic bit m_trap(input int size, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One access: start in cycle 0, bus_ack in cycle k (k > TO means never acked).
    task automatic do_access(input bit load, input int size, input bit uns, input logic [31:0] a,
                             input logic [31:0] wd, input int k, input logic [31:0] word);
        logic [31:0] rd_exp = m_load(size, uns, a, word);
        bit          trap   = m_trap(size, a);
        int          last   = (k < int'(TO)) ? k : int'(TO);

        next_cycle();
        start = 1'b1; mem_opcode = {load, 2'(size)}; mem_unsigned = uns; addr = a; wdata = wd;
        bus_ack = 1'b0;
        #1;
        chk("stall_c0", stall, 1);

        if (trap) begin
            next_cycle();
            start = 1'b0; addr = $urandom; wdata = $urandom;
            #1;
            chk("trap_err", err, 1);
            chk("trap_req", bus_req, 0);
            chk("trap_stall", stall, 1);
            chk("trap_valid", rdata_valid, 0);
            next_cycle();
            #1;
            chk("trap_err_end", err, 0);
            chk("trap_req_end", bus_req, 0);
            chk("trap_stall_end", stall, 0);
            return;
        end

        for (int c = 1; c <= last; c++) begin
            next_cycle();
            start = 1'b0; addr = $urandom; wdata = $urandom; mem_opcode = 3'($urandom);
            bus_ack = (c == k);
            bus_rdata = (c == k) ? word : $urandom;
            #1;
            chk("req_held", bus_req, 1);
            chk("req_stall", stall, 1);
            chk("req_valid", rdata_valid, 0);
            chk("req_err", err, 0);
            if (c == 1) begin
                cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_be", bus_be, m_be(size, a));
                chk("bus_we", bus_we, !load);
                chk("bus_wdata", bus_wdata, m_wdata(size, wd));
            end
        end

        if (k <= int'(TO)) begin
            next_cycle();
            bus_ack = 1'($urandom);
            bus_rdata = $urandom;
            #1;
            chk("resp_valid", rdata_valid, load);
            chk("resp_req", bus_req, 0);
            chk("resp_stall", stall, 1);
            chk("resp_err", err, 0);
            if (load) exp_rdata = rd_exp;
            chk("resp_rdata", rdata, exp_rdata);
            next_cycle();
            bus_ack = 1'b0;
            #1;
            chk("done_stall", stall, 0);
            chk("done_valid", rdata_valid, 0);
            chk("done_rdata", rdata, exp_rdata);
        end else begin
            next_cycle();
            #1;
            chk("to_err", err, 1);
            chk("to_req", bus_req, 0);
            chk("to_stall", stall, 0);
            chk("to_valid", rdata_valid, 0);
            chk("to_rdata", rdata, exp_rdata);
        end
    endtask

    task automatic do_nop();
        next_cycle();
        start = 1'b1; mem_opcode = {1'($urandom), 2'b11};
        #1;
        chk("nop_stall", stall, 0);
        next_cycle();
        start = 1'b0;
        #1;
        chk("nop_req", bus_req, 0);
        chk("nop_stall_next", stall, 0);
    endtask

    task automatic do_idle_ack();
        next_cycle();
        bus_ack = 1'b1; bus_rdata = $urandom;
        #1;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        chk("idle_ack_valid", rdata_valid, 0);
        chk("idle_ack_rdata", rdata, exp_rdata);
        chk("idle_ack_stall", stall, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; mem_opcode = 3'b011; mem_unsigned = 1'b0;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        exp_rdata = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Store byte, ack in cycle 3.
        do_access(1'b0, 0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 3, $urandom);
        chk("sb_be", cap_be, 4'b1000);
        chk("sb_addr", cap_addr, 32'h0000_1000);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);

        // Half loads, signed and unsigned.
        do_access(1'b1, 1, 1'b0, 32'h0000_2002, 32'h0, 2, 32'h8001_0000);
        chk("lh_signed", rdata, 32'hFFFF_8001);
        do_access(1'b1, 1, 1'b1, 32'h0000_2002, 32'h0, 2, 32'h8001_0000);
        chk("lh_unsigned", rdata, 32'h0000_8001);

        // Word load, ack in cycle 1.
        do_access(1'b1, 2, 1'b0, 32'h0000_3000, 32'h0, 1, 32'hDEAD_BEEF);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);

        // Timeout, then ack in the very last counted cycle.
        do_access(1'b1, 2, 1'b0, 32'h0000_4000, 32'h0, int'(TO) + 5, 32'h0);
        do_access(1'b1, 2, 1'b0, 32'h0000_4004, 32'h0, int'(TO), 32'h1234_5678);
        chk("ack_at_timeout", rdata, 32'h1234_5678);

        do_nop();
        do_idle_ack();

        // Reset in the middle of REQ.
        next_cycle();
        start = 1'b1; mem_opcode = 3'b110; addr = 32'h0000_5000;
        next_cycle();
        start = 1'b0;
        #1;
        chk("mid_req_up", bus_req, 1);
        next_cycle();
        start = 1'b1; rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_addr", bus_addr, 0);
        chk("mid_rst_rdata", rdata, 0);
        exp_rdata = '0;
        next_cycle();
        start = 1'b0;
        rst_n = 1'b1;
        do_access(1'b1, 0, 1'b0, 32'h0000_6001, 32'h0, 2, 32'h0000_8000);
        chk("post_rst_lb", rdata, 32'hFFFF_FF80);

`ifdef MEM_MISALIGN_TRAP_EN
        do_access(1'b1, 2, 1'b0, 32'h0000_1001, 32'h0, 1, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            int unsigned sel = $urandom_range(0, 9);
            if (sel == 0) do_nop();
            else if (sel == 1) do_idle_ack();
            else do_access(1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), $urandom,
                           $urandom, int'($urandom_range(1, TO + 2)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
